// File: rtl/bmp_copy_pkg.sv
// Shared types and constants for the BMP ROM-to-RAM copy engine.
// Image sizing constants are also used by the top-level loader controller.
package bmp_copy_pkg;

    localparam int DEF_DATA_W      = 8;
    localparam int DEF_ADDR_W      = 20;
    localparam int BMP_HDR_BYTES   = 54;
    localparam int BMP_IMG_W       = 640;
    localparam int BMP_IMG_H       = 480;
    localparam int BMP_TOTAL_BYTES = BMP_HDR_BYTES + BMP_IMG_W * BMP_IMG_H * 3;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DRAIN,
        ST_DONE
    } state_e;

endpackage

// File: rtl/bmp_copy_engine_if.sv
// Control, ROM and RAM signals of the copy engine bundled as one interface.
// master = controller/memory side, slave = engine side.
interface bmp_copy_engine_if #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 20,
    parameter int PACK   = 1
);
    logic                   start;
    logic                   abort;
    logic [ADDR_W-1:0]      src_base;
    logic [ADDR_W-1:0]      dst_base;
    logic [ADDR_W-1:0]      length;
    logic                   rom_ren;
    logic [ADDR_W-1:0]      rom_addr;
    logic [DATA_W-1:0]      rom_data;
    logic                   ram_wen;
    logic [ADDR_W-1:0]      ram_addr;
    logic [PACK*DATA_W-1:0] ram_wdata;
    logic                   busy;
    logic                   done;

    modport master (
        output start, abort, src_base, dst_base, length, rom_data,
        input  rom_ren, rom_addr, ram_wen, ram_addr, ram_wdata, busy, done
    );

    modport slave (
        input  start, abort, src_base, dst_base, length, rom_data,
        output rom_ren, rom_addr, ram_wen, ram_addr, ram_wdata, busy, done
    );
endinterface

// File: rtl/bmp_byte_packer.sv
// Packs DATA_W bytes little-endian into PACK-byte words; one cycle from last lane to word pulse.
// No backpressure: a byte is accepted every cycle it is valid; flush drops a partial word.
module bmp_byte_packer #(
    parameter int DATA_W = 8,
    parameter int PACK   = 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   flush_i,
    input  logic                   byte_vld_i,
    input  logic [DATA_W-1:0]      byte_dat_i,
    input  logic                   byte_last_i,
    output logic                   word_vld_o,
    output logic [PACK*DATA_W-1:0] word_dat_o,
    output logic                   word_last_o
);
    localparam int WORD_W = PACK * DATA_W;

    logic [2:0]        lane_q, lane_d;
    logic [WORD_W-1:0] acc_q, acc_d, word_q, word_d, merged;
    logic              vld_q, vld_d, last_q, last_d;

    always_comb begin
        merged = acc_q | (WORD_W'(byte_dat_i) << (lane_q * DATA_W));
        lane_d = lane_q;
        acc_d  = acc_q;
        word_d = word_q;
        vld_d  = 1'b0;
        last_d = last_q;
        if (flush_i) begin
            lane_d = '0;
            acc_d  = '0;
        end else if (byte_vld_i) begin
            if (lane_q == 3'(PACK - 1) || byte_last_i) begin
                // Accumulator restarts from zero, so a short final word has empty upper lanes.
                word_d = merged;
                vld_d  = 1'b1;
                last_d = byte_last_i;
                lane_d = '0;
                acc_d  = '0;
            end else begin
                acc_d  = merged;
                lane_d = lane_q + 3'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            lane_q <= '0;
            acc_q  <= '0;
            word_q <= '0;
            vld_q  <= 1'b0;
            last_q <= 1'b0;
        end else begin
            lane_q <= lane_d;
            acc_q  <= acc_d;
            word_q <= word_d;
            vld_q  <= vld_d;
            last_q <= last_d;
        end
    end

    assign word_vld_o  = vld_q;
    assign word_dat_o  = word_q;
    assign word_last_o = last_q;
endmodule

// File: rtl/bmp_copy_engine.sv
// Copies a byte range from image ROM into frame RAM at one ROM read per cycle.
// Final write lands length+ROM_LAT+1 cycles after start; no backpressure, abort cancels.
module bmp_copy_engine
    import bmp_copy_pkg::*;
#(
    parameter int DATA_W  = DEF_DATA_W,
    parameter int ADDR_W  = DEF_ADDR_W,
    parameter int ROM_LAT = 1,
    parameter int PACK    = 1
) (
    input  logic               clk,
    input  logic               rst,
    bmp_copy_engine_if.slave   bus
);
    localparam int WORD_W = PACK * DATA_W;

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   src_q, src_d, len_q, len_d;
    logic [ADDR_W-1:0]   issued_q, issued_d, rcv_q, rcv_d;
    logic [ADDR_W-1:0]   rom_addr_q, rom_addr_d, ram_addr_q, ram_addr_d;
    logic                rom_ren_q, rom_ren_d;
    logic [ROM_LAT-1:0]  vld_sr_q, vld_sr_d;
    logic                flush, byte_vld, byte_last, word_vld, word_last;
    logic [WORD_W-1:0]   word_dat;

    assign byte_vld  = vld_sr_q[ROM_LAT-1];
    assign byte_last = (rcv_q == len_q - ADDR_W'(1));

    always_comb begin
        state_d    = state_q;
        src_d      = src_q;
        len_d      = len_q;
        issued_d   = issued_q;
        rom_ren_d  = 1'b0;
        rom_addr_d = rom_addr_q;
        ram_addr_d = word_vld ? ram_addr_q + ADDR_W'(1) : ram_addr_q;
        rcv_d      = byte_vld ? rcv_q + ADDR_W'(1) : rcv_q;
        vld_sr_d   = (vld_sr_q << 1) | ROM_LAT'(rom_ren_q);
        flush      = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    src_d      = bus.src_base;
                    len_d      = bus.length;
                    ram_addr_d = bus.dst_base;
                    rcv_d      = '0;
                    issued_d   = '0;
                    flush      = 1'b1;
                    if (bus.length != '0) begin
                        state_d    = ST_RUN;
                        rom_ren_d  = 1'b1;
                        rom_addr_d = bus.src_base;
                        issued_d   = ADDR_W'(1);
                    end else begin
                        state_d = ST_DONE;
                    end
                end
            end
            ST_RUN: begin
                if (issued_q == len_q) begin
                    state_d = ST_DRAIN;
                end else begin
                    rom_ren_d  = 1'b1;
                    rom_addr_d = src_q + issued_q;
                    issued_d   = issued_q + ADDR_W'(1);
                end
            end
            ST_DRAIN: begin
                if (word_vld && word_last) state_d = ST_DONE;
            end
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
        // Abort drops reads still in the latency pipe and any partially packed word.
        if (bus.abort && (state_q == ST_RUN || state_q == ST_DRAIN)) begin
            state_d   = ST_IDLE;
            rom_ren_d = 1'b0;
            vld_sr_d  = '0;
            flush     = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            src_q      <= '0;
            len_q      <= '0;
            issued_q   <= '0;
            rcv_q      <= '0;
            rom_ren_q  <= 1'b0;
            rom_addr_q <= '0;
            ram_addr_q <= '0;
            vld_sr_q   <= '0;
        end else begin
            state_q    <= state_d;
            src_q      <= src_d;
            len_q      <= len_d;
            issued_q   <= issued_d;
            rcv_q      <= rcv_d;
            rom_ren_q  <= rom_ren_d;
            rom_addr_q <= rom_addr_d;
            ram_addr_q <= ram_addr_d;
            vld_sr_q   <= vld_sr_d;
        end
    end

    bmp_byte_packer #(
        .DATA_W (DATA_W),
        .PACK   (PACK)
    ) u_packer (
        .clk         (clk),
        .rst         (rst),
        .flush_i     (flush),
        .byte_vld_i  (byte_vld && !flush),
        .byte_dat_i  (bus.rom_data),
        .byte_last_i (byte_last),
        .word_vld_o  (word_vld),
        .word_dat_o  (word_dat),
        .word_last_o (word_last)
    );

    assign bus.rom_ren   = rom_ren_q;
    assign bus.rom_addr  = rom_addr_q;
    assign bus.ram_wen   = word_vld;
    assign bus.ram_addr  = ram_addr_q;
    assign bus.ram_wdata = word_dat;
    assign bus.busy      = (state_q == ST_RUN) || (state_q == ST_DRAIN);
    assign bus.done      = (state_q == ST_DONE);
endmodule

// File: tb/tb_bmp_copy_engine.sv
// Directed bench: engine A (PACK=1, ROM_LAT=1) and engine B (PACK=3, ROM_LAT=2).
// Strobes are logged per cycle relative to the start edge and compared after each transfer.
module tb_bmp_copy_engine;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    int cyc = 0;
    int base = 0;
    int checks = 0;
    int failures = 0;
    always @(posedge clk) cyc++;

    bmp_copy_engine_if #(.DATA_W(8), .ADDR_W(20), .PACK(1)) ifa ();
    bmp_copy_engine_if #(.DATA_W(8), .ADDR_W(20), .PACK(3)) ifb ();

    bmp_copy_engine #(.DATA_W(8), .ADDR_W(20), .ROM_LAT(1), .PACK(1)) dut_a (
        .clk (clk), .rst (rst), .bus (ifa)
    );
    bmp_copy_engine #(.DATA_W(8), .ADDR_W(20), .ROM_LAT(2), .PACK(3)) dut_b (
        .clk (clk), .rst (rst), .bus (ifb)
    );

    // ROM content: byte at address a is a[7:0]+1
    function automatic logic [7:0] rom_f(input logic [19:0] a);
        return a[7:0] + 8'd1;
    endfunction

    logic [7:0] pa1, pb1, pb2;
    always @(posedge clk) begin
        pa1 <= rom_f(ifa.rom_addr);
        pb1 <= rom_f(ifb.rom_addr);
        pb2 <= pb1;
    end
    assign ifa.rom_data = pa1;
    assign ifb.rom_data = pb2;

    int ra_cyc[$], ra_adr[$], wa_cyc[$], wa_adr[$], wa_dat[$], da_cyc[$];
    int wb_cyc[$], wb_adr[$], wb_dat[$], db_cyc[$];
    int busy_a, done_busy_a, rb_n;

    always @(negedge clk) begin
        if (!rst) begin
            if (ifa.rom_ren) begin
                ra_cyc.push_back(cyc - base);
                ra_adr.push_back(int'(ifa.rom_addr));
            end
            if (ifa.ram_wen) begin
                wa_cyc.push_back(cyc - base);
                wa_adr.push_back(int'(ifa.ram_addr));
                wa_dat.push_back(int'(ifa.ram_wdata));
            end
            if (ifa.busy) busy_a++;
            if (ifa.done) begin
                da_cyc.push_back(cyc - base);
                done_busy_a = int'(ifa.busy);
            end
            if (ifb.rom_ren) rb_n++;
            if (ifb.ram_wen) begin
                wb_cyc.push_back(cyc - base);
                wb_adr.push_back(int'(ifb.ram_addr));
                wb_dat.push_back(int'(ifb.ram_wdata));
            end
            if (ifb.done) db_cyc.push_back(cyc - base);
        end
    end

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic clr();
        ra_cyc.delete(); ra_adr.delete(); wa_cyc.delete(); wa_adr.delete();
        wa_dat.delete(); da_cyc.delete(); wb_cyc.delete(); wb_adr.delete();
        wb_dat.delete(); db_cyc.delete();
        busy_a = 0; done_busy_a = -1; rb_n = 0;
    endtask

    // Start is driven during cycle -1 so that it is sampled at edge 0.
    task automatic start_a(input logic [19:0] s, input logic [19:0] d, input logic [19:0] l);
        tick();
        ifa.src_base = s; ifa.dst_base = d; ifa.length = l; ifa.start = 1'b1;
        clr();
        base = cyc;
        tick();
        ifa.start = 1'b0;
    endtask

    task automatic start_b(input logic [19:0] s, input logic [19:0] d, input logic [19:0] l);
        tick();
        ifb.src_base = s; ifb.dst_base = d; ifb.length = l; ifb.start = 1'b1;
        clr();
        base = cyc;
        tick();
        ifb.start = 1'b0;
    endtask

    int exp_b_dat[3] = '{32'h030201, 32'h060504, 32'h000007};
    int exp_b_cyc[3] = '{6, 9, 10};
    int exp_wrap[4]  = '{32'hFFFFE, 32'hFFFFF, 32'h00000, 32'h00001};
    int exp_wdat[4]  = '{32'hFF, 32'h00, 32'h01, 32'h02};

    initial begin
        ifa.start = 0; ifa.abort = 0; ifa.src_base = 0; ifa.dst_base = 0; ifa.length = 0;
        ifb.start = 0; ifb.abort = 0; ifb.src_base = 0; ifb.dst_base = 0; ifb.length = 0;
        clr();
        rst = 1'b1;
        repeat (3) tick();
        rst = 1'b0;
        tick();
        chk("rst_rom_ren",   int'(ifa.rom_ren),   0);
        chk("rst_rom_addr",  int'(ifa.rom_addr),  0);
        chk("rst_ram_wen",   int'(ifa.ram_wen),   0);
        chk("rst_ram_addr",  int'(ifa.ram_addr),  0);
        chk("rst_ram_wdata", int'(ifa.ram_wdata), 0);
        chk("rst_busy",      int'(ifa.busy),      0);
        chk("rst_done",      int'(ifa.done),      0);
        chk("rst_b_wdata",   int'(ifb.ram_wdata), 0);

        // Basic PACK=1 transfer
        start_a(20'h10, 20'h200, 20'd4);
        repeat (10) tick();
        chk("t1_rd_n", ra_cyc.size(), 4);
        for (int i = 0; i < 4; i++) begin
            chk("t1_rd_cyc", ra_cyc[i], i + 1);
            chk("t1_rd_adr", ra_adr[i], 32'h10 + i);
        end
        chk("t1_wr_n", wa_cyc.size(), 4);
        for (int i = 0; i < 4; i++) begin
            chk("t1_wr_cyc", wa_cyc[i], i + 3);
            chk("t1_wr_adr", wa_adr[i], 32'h200 + i);
            chk("t1_wr_dat", wa_dat[i], 32'h11 + i);
        end
        chk("t1_done_n", da_cyc.size(), 1);
        chk("t1_done_cyc", da_cyc[0], 7);
        chk("t1_done_busy", done_busy_a, 0);
        chk("t1_busy_cycles", busy_a, 6);

        // PACK=3, ROM_LAT=2 with partial final word
        start_b(20'h0, 20'h100, 20'd7);
        repeat (14) tick();
        chk("t2_rd_n", rb_n, 7);
        chk("t2_wr_n", wb_cyc.size(), 3);
        for (int i = 0; i < 3; i++) begin
            chk("t2_wr_cyc", wb_cyc[i], exp_b_cyc[i]);
            chk("t2_wr_adr", wb_adr[i], 32'h100 + i);
            chk("t2_wr_dat", wb_dat[i], exp_b_dat[i]);
        end
        chk("t2_done_n", db_cyc.size(), 1);
        chk("t2_done_cyc", db_cyc[0], 11);

        // Zero length
        start_a(20'h30, 20'h700, 20'd0);
        repeat (4) tick();
        chk("t3_rd_n", ra_cyc.size(), 0);
        chk("t3_wr_n", wa_cyc.size(), 0);
        chk("t3_done_n", da_cyc.size(), 1);
        chk("t3_done_cyc", da_cyc[0], 1);
        chk("t3_busy_cycles", busy_a, 0);

        // Abort during cycle 3 of a 10-byte transfer
        start_a(20'h40, 20'h300, 20'd10);
        repeat (2) tick();
        ifa.abort = 1'b1;
        tick();
        ifa.abort = 1'b0;
        repeat (10) tick();
        chk("t4_rd_n", ra_cyc.size(), 3);
        chk("t4_rd_last_cyc", ra_cyc[2], 3);
        chk("t4_wr_n", wa_cyc.size(), 1);
        chk("t4_wr_cyc", wa_cyc[0], 3);
        chk("t4_wr_dat", wa_dat[0], 32'h41);
        chk("t4_done_n", da_cyc.size(), 0);
        chk("t4_busy_after", int'(ifa.busy), 0);

        start_a(20'h50, 20'h400, 20'd2);
        repeat (8) tick();
        chk("t4b_wr_n", wa_cyc.size(), 2);
        for (int i = 0; i < 2; i++) begin
            chk("t4b_wr_adr", wa_adr[i], 32'h400 + i);
            chk("t4b_wr_dat", wa_dat[i], 32'h51 + i);
        end
        chk("t4b_done_cyc", da_cyc[0], 5);

        // Source address wrap
        start_a(20'hFFFFE, 20'h0, 20'd4);
        repeat (8) tick();
        chk("t5_rd_n", ra_adr.size(), 4);
        for (int i = 0; i < 4; i++) begin
            chk("t5_rd_adr", ra_adr[i], exp_wrap[i]);
            chk("t5_wr_dat", wa_dat[i], exp_wdat[i]);
        end
        chk("t5_done_cyc", da_cyc[0], 7);

        // Second start mid-transfer with different parameters
        start_a(20'h20, 20'h500, 20'd3);
        tick();
        ifa.src_base = 20'h80; ifa.dst_base = 20'h600; ifa.length = 20'd8; ifa.start = 1'b1;
        tick();
        ifa.start = 1'b0;
        repeat (8) tick();
        chk("t6_rd_n", ra_adr.size(), 3);
        chk("t6_wr_n", wa_adr.size(), 3);
        for (int i = 0; i < 3; i++) begin
            chk("t6_rd_adr", ra_adr[i], 32'h20 + i);
            chk("t6_wr_adr", wa_adr[i], 32'h500 + i);
            chk("t6_wr_dat", wa_dat[i], 32'h21 + i);
        end
        chk("t6_done_n", da_cyc.size(), 1);
        chk("t6_done_cyc", da_cyc[0], 6);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
